// File: rtl/countdown_sequencer.sv
// Seconds countdown controller driving a tick-enable divider.
// Define COUNTDOWN_AUTORELOAD_EN for periodic reload-on-expiry.
module countdown_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             fast_req,
  output logic             div_reset,
  output logic             fast_mode,
  output logic [WIDTH-1:0] remaining,
  output logic             running,
  output logic             expired,
  output logic             alarm
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    RUN,
    PAUSED,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_nxt;
  logic [WIDTH-1:0] rem_nxt;
  logic             expired_nxt;
  logic             fast_nxt;

  always_comb begin
    state_nxt   = state;
    reload_nxt  = reload;
    rem_nxt     = remaining;
    expired_nxt = 1'b0;
    fast_nxt    = fast_mode;
    unique case (state)
      IDLE: begin
        if (stop) begin
          rem_nxt = reload;
        end else if (load) begin
          reload_nxt = load_value;
          rem_nxt    = load_value;
        end else if (start && remaining != ZERO) begin
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        fast_nxt  = fast_req;
        state_nxt = RUN;
      end
      RUN: begin
        if (stop) begin
          rem_nxt   = reload;
          state_nxt = IDLE;
        end else if (tick_in && remaining == ONE) begin
          // Expiry overrides a same-cycle pause.
          expired_nxt = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          rem_nxt   = reload;
          state_nxt = (reload != ZERO) ? SYNC : IDLE;
`else
          rem_nxt   = ZERO;
          state_nxt = DONE;
`endif
        end else begin
          if (tick_in && remaining != ZERO)
            rem_nxt = remaining - ONE;
          if (pause)
            state_nxt = PAUSED;
        end
      end
      PAUSED: begin
        if (stop) begin
          rem_nxt   = reload;
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = SYNC;
        end
      end
      DONE: begin
        if (stop) begin
          rem_nxt   = reload;
          state_nxt = IDLE;
        end else if (load) begin
          reload_nxt = load_value;
          rem_nxt    = load_value;
          state_nxt  = IDLE;
        end else if (start) begin
          rem_nxt   = reload;
          state_nxt = (reload != ZERO) ? SYNC : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      reload    <= ZERO;
      remaining <= ZERO;
      div_reset <= 1'b1;
      fast_mode <= 1'b0;
      running   <= 1'b0;
      expired   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_nxt;
      reload    <= reload_nxt;
      remaining <= rem_nxt;
      fast_mode <= fast_nxt;
      expired   <= expired_nxt;
      div_reset <= (state_nxt == SYNC);
      running   <= (state_nxt == SYNC) || (state_nxt == RUN);
      alarm     <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed vector bench for countdown_sequencer.
// Each vector: inputs for one edge, outputs expected just after it.
module tb_countdown_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tick_in;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic       pause;
  logic       stop;
  logic       fast_req;
  logic       div_reset;
  logic       fast_mode;
  logic [7:0] remaining;
  logic       running;
  logic       expired;
  logic       alarm;

  int passes = 0;
  int total  = 0;

  countdown_sequencer #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .tick_in    (tick_in),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .fast_req   (fast_req),
    .div_reset  (div_reset),
    .fast_mode  (fast_mode),
    .remaining  (remaining),
    .running    (running),
    .expired    (expired),
    .alarm      (alarm)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       pa;
    logic       sp;
    logic       tk;
    logic       fr;
    logic [7:0] rem;
    logic       run;
    logic       dr;
    logic       ex;
    logic       al;
    logic       fm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm,
                     input logic ld, input logic [7:0] lv,
                     input logic st, input logic pa,
                     input logic sp, input logic tk,
                     input logic fr,
                     input logic [7:0] rem, input logic run,
                     input logic dr, input logic ex,
                     input logic al, input logic fm);
    vec_t v;
    v.name = nm;
    v.ld = ld; v.lv = lv; v.st = st; v.pa = pa;
    v.sp = sp; v.tk = tk; v.fr = fr;
    v.rem = rem; v.run = run; v.dr = dr;
    v.ex = ex; v.al = al; v.fm = fm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm,
                       input logic [7:0] rem, input logic run,
                       input logic dr, input logic ex,
                       input logic al, input logic fm);
    total++;
    if ({remaining, running, div_reset, expired, alarm, fast_mode}
        === {rem, run, dr, ex, al, fm}) begin
      passes++;
    end else begin
      $display("FAIL %s: got rem=%0d run=%b dr=%b ex=%b al=%b fm=%b, want rem=%0d run=%b dr=%b ex=%b al=%b fm=%b",
               nm, remaining, running, div_reset, expired, alarm,
               fast_mode, rem, run, dr, ex, al, fm);
    end
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      load       = vecs[i].ld;
      load_value = vecs[i].lv;
      start      = vecs[i].st;
      pause      = vecs[i].pa;
      stop       = vecs[i].sp;
      tick_in    = vecs[i].tk;
      fast_req   = vecs[i].fr;
      @(posedge clock);
      #1;
      check(vecs[i].name, vecs[i].rem, vecs[i].run,
            vecs[i].dr, vecs[i].ex, vecs[i].al, vecs[i].fm);
    end
    vecs.delete();
    load = 0; start = 0; pause = 0; stop = 0; tick_in = 0;
  endtask

  initial begin
    reset_n = 0; tick_in = 0; load = 0; load_value = 0;
    start = 0; pause = 0; stop = 0; fast_req = 0;
    @(posedge clock);
    #1;
    check("reset", 8'd0, 0, 1, 0, 0, 0);
    reset_n = 1;

    //   name          ld lv  st pa sp tk fr  rem run dr ex al fm
    add("a_load3",      1, 3, 0, 0, 0, 0, 1,  3, 0, 0, 0, 0, 0);
    add("a_start",      0, 0, 1, 0, 0, 0, 1,  3, 1, 1, 0, 0, 0);
    add("a_sync_tick",  0, 0, 0, 0, 0, 1, 1,  3, 1, 0, 0, 0, 1);
    add("a_run_idle",   0, 0, 0, 0, 0, 0, 1,  3, 1, 0, 0, 0, 1);
    add("a_tick2",      0, 0, 0, 0, 0, 1, 1,  2, 1, 0, 0, 0, 1);
    add("a_tick1",      0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 0, 0, 1);
`ifdef COUNTDOWN_AUTORELOAD_EN
    add("a_expire",     0, 0, 0, 0, 0, 1, 1,  3, 1, 1, 1, 0, 1);
    add("a_after",      0, 0, 0, 0, 0, 0, 1,  3, 1, 0, 0, 0, 1);
`else
    add("a_expire",     0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 1, 1);
    add("a_alarm_hold", 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1);
`endif
    add("a_stop",       0, 0, 0, 0, 1, 0, 1,  3, 0, 0, 0, 0, 1);
    add("b_load4",      1, 4, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 1);
    add("b_start",      0, 0, 1, 0, 0, 0, 0,  4, 1, 1, 0, 0, 1);
    add("b_sync",       0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0, 0, 0);
    add("b_load_run",   1, 9, 0, 0, 0, 0, 0,  4, 1, 0, 0, 0, 0);
    add("b_tick3",      0, 0, 0, 0, 0, 1, 0,  3, 1, 0, 0, 0, 0);
    add("b_tick2",      0, 0, 0, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0);
    add("b_stop",       0, 0, 0, 0, 1, 0, 0,  4, 0, 0, 0, 0, 0);
    add("b_load0",      1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add("b_start0",     0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add("b_start0_n",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add("c_load2",      1, 2, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0);
    add("c_start",      0, 0, 1, 0, 0, 0, 0,  2, 1, 1, 0, 0, 0);
    add("c_sync",       0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0);
    add("c_tick_stop",  0, 0, 0, 0, 1, 1, 0,  2, 0, 0, 0, 0, 0);
    add("d_load5",      1, 5, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0);
    add("d_start",      0, 0, 1, 0, 0, 0, 0,  5, 1, 1, 0, 0, 0);
    add("d_sync",       0, 0, 0, 0, 0, 0, 0,  5, 1, 0, 0, 0, 0);
    add("d_tick4",      0, 0, 0, 0, 0, 1, 0,  4, 1, 0, 0, 0, 0);
    add("d_tick3",      0, 0, 0, 0, 0, 1, 0,  3, 1, 0, 0, 0, 0);
    add("d_pause",      0, 0, 0, 1, 0, 0, 0,  3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add("d_paused_tk", 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0);
    add("d_paused_ld",  1, 9, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
    add("e_resume",     0, 0, 1, 0, 0, 0, 0,  3, 1, 1, 0, 0, 0);
    add("e_sync",       0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0);
    add("e_tick2",      0, 0, 0, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0);
    add("e_tick_pause", 0, 0, 0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0);
    add("e_resume2",    0, 0, 1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0);
    add("e_sync2",      0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    run_table();

    // Final tick together with pause: expiry must win.
    pause = 1; tick_in = 1;
    @(posedge clock);
    #1;
    pause = 0; tick_in = 0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    check("e_last_pause", 8'd5, 1, 1, 1, 0, 0);
    @(posedge clock);
    #1;
    check("e_after", 8'd5, 1, 0, 0, 0, 0);
    add("e_stop",       0, 0, 0, 0, 1, 0, 0,  5, 0, 0, 0, 0, 0);
    add("g_load2",      1, 2, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0);
    add("g_start",      0, 0, 1, 0, 0, 0, 0,  2, 1, 1, 0, 0, 0);
    add("g_sync",       0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0);
    add("g_tick1",      0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0);
    add("g_reload",     0, 0, 0, 0, 0, 1, 0,  2, 1, 1, 1, 0, 0);
    add("g_sync2",      0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0);
    add("g_tick1b",     0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0);
    add("g_reload2",    0, 0, 0, 0, 0, 1, 0,  2, 1, 1, 1, 0, 0);
    add("g_stop",       0, 0, 0, 0, 1, 0, 0,  2, 0, 0, 0, 0, 0);
`else
    check("e_last_pause", 8'd0, 0, 0, 1, 1, 0);
    @(posedge clock);
    #1;
    check("e_done", 8'd0, 0, 0, 0, 1, 0);
    add("e_restart",    0, 0, 1, 0, 0, 0, 0,  5, 1, 1, 0, 0, 0);
    add("e_sync3",      0, 0, 0, 0, 0, 0, 0,  5, 1, 0, 0, 0, 0);
    add("e_stop",       0, 0, 0, 0, 1, 0, 0,  5, 0, 0, 0, 0, 0);
    add("f_load1",      1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add("f_start",      0, 0, 1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0);
    add("f_sync",       0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    add("f_expire",     0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1, 0);
    add("f_done_load",  1, 7, 0, 0, 0, 0, 0,  7, 0, 0, 0, 0, 0);
`endif
    add("h_load3",      1, 3, 0, 0, 0, 0, 1,  3, 0, 0, 0, 0, 0);
    add("h_start",      0, 0, 1, 0, 0, 0, 1,  3, 1, 1, 0, 0, 0);
    add("h_sync",       0, 0, 0, 0, 0, 0, 1,  3, 1, 0, 0, 0, 1);
    run_table();

    // Reset in the middle of a run.
    reset_n = 0;
    @(posedge clock);
    #1;
    check("mid_reset", 8'd0, 0, 1, 0, 0, 0);
    reset_n = 1;
    @(posedge clock);
    #1;
    check("post_reset", 8'd0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
